// File: rtl/i_prefetch_queue.sv
// i_prefetch_queue: DEPTH-entry instruction prefetch queue feeding the decoder.
// Bus bytes are pushed with the active-low loadn strobe. advance pops the
// oldest entry into instr_out. flush discards prefetched entries on jumps.
// overflow is sticky and records loads that were dropped while the queue was full.
module i_prefetch_queue #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   loadn,
  input  logic                   advance,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       bus,
  output logic [WIDTH-1:0]       instr_out,
  output logic                   instr_valid,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full,
  output logic                   overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    head, tail;
  logic [PW-1:0]    head_next, tail_next, wr_addr;
  logic [CW-1:0]    count_next;
  logic             do_pop, do_push, drop;

  // Strobe qualification and next pointer/count values.
  // A flush rebases the queue at slot 0. Any same-edge load therefore lands in slot 0.
  always_comb begin
    do_pop     = !flush && advance && (count != '0);
    do_push    = !loadn && (flush || !full || do_pop);
    drop       = !loadn && !flush && full && !do_pop;
    wr_addr    = tail;
    head_next  = head;
    tail_next  = tail;
    count_next = count;
    if (flush) begin
      wr_addr    = '0;
      head_next  = '0;
      tail_next  = do_push ? PW'(1) : '0;
      count_next = do_push ? CW'(1) : '0;
    end else begin
      head_next  = head + PW'(do_pop);
      tail_next  = tail + PW'(do_push);
      count_next = count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Queue storage. Reset does not clear it, because entries are only read after a push.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_addr] <= bus;
  end

  // Pointers, occupancy and status flags. empty and full are registered from count_next, so they stay consistent with count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      head  <= head_next;
      tail  <= tail_next;
      count <= count_next;
      empty <= (count_next == '0);
      full  <= (count_next == DEPTH_C);
      if (flush)     overflow <= 1'b0;
      else if (drop) overflow <= 1'b1;
    end
  end

  // Decoder-facing instruction register. An advance while the queue is empty presents a NOP (zero).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_out   <= '0;
      instr_valid <= 1'b0;
    end else if (flush) begin
      instr_out   <= '0;
      instr_valid <= 1'b0;
    end else if (do_pop) begin
      instr_out   <= mem[head];
      instr_valid <= 1'b1;
    end else if (advance) begin
      instr_out   <= '0;
      instr_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i_prefetch_queue.sv
// Directed testbench for i_prefetch_queue with WIDTH=8 and DEPTH=4.
module tb_i_prefetch_queue;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       loadn = 1'b1;
  logic       advance = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] bus = '0;
  logic [7:0] instr_out;
  logic       instr_valid;
  logic [2:0] count;
  logic       empty, full, overflow;

  logic [14:0] obs;
  logic [14:0] exp;
  int total = 0;
  int bad = 0;

  i_prefetch_queue #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .loadn(loadn), .advance(advance), .flush(flush),
    .bus(bus), .instr_out(instr_out), .instr_valid(instr_valid), .count(count),
    .empty(empty), .full(full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  assign obs = {instr_out, instr_valid, count, empty, full, overflow};

  // Expected output vector: {instr_out, instr_valid, count, empty, full, overflow}.
  function automatic logic [14:0] ev(input logic [7:0] i, input logic v, input int c, input logic o);
    return {i, v, 3'(c), (c == 0), (c == 4), o};
  endfunction

  // Applies one set of strobes for one rising edge and samples 1 time unit after that edge.
  task automatic cycle(input logic ld_n, input logic adv, input logic fl, input logic [7:0] b);
    loadn = ld_n; advance = adv; flush = fl; bus = b;
    @(posedge clk); #1;
    loadn = 1'b1; advance = 1'b0; flush = 1'b0; bus = '0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    @(posedge clk); #1;
    exp = ev(8'h00, 0, 0, 0); total++;
    if (obs !== exp) begin bad++; $display("FAIL reset obs=%h exp=%h", obs, exp); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fifo_order;
    logic [7:0] vals [3] = '{8'h11, 8'h22, 8'h33};
    for (int unsigned k = 0; k < 3; k++) begin
      cycle(0, 0, 0, vals[k]);
      exp = ev(8'h00, 0, int'(k) + 1, 0); total++;
      if (obs !== exp) begin bad++; $display("FAIL order_push%0d obs=%h exp=%h", k, obs, exp); end
    end
    for (int unsigned k = 0; k < 3; k++) begin
      cycle(1, 1, 0, 8'h00);
      exp = ev(vals[k], 1, 2 - int'(k), 0); total++;
      if (obs !== exp) begin bad++; $display("FAIL order_pop%0d obs=%h exp=%h", k, obs, exp); end
      if (k == 0) begin
        cycle(1, 0, 0, 8'h00);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL order_hold obs=%h exp=%h", obs, exp); end
      end
    end
  endtask

  task automatic test_overflow;
    for (int unsigned k = 0; k < 4; k++) cycle(0, 0, 0, 8'hA0 + 8'(k));
    exp = ev(8'h33, 1, 4, 0); total++;
    if (obs !== exp) begin bad++; $display("FAIL ovf_full obs=%h exp=%h", obs, exp); end
    cycle(0, 0, 0, 8'hA4);
    exp = ev(8'h33, 1, 4, 1); total++;
    if (obs !== exp) begin bad++; $display("FAIL ovf_drop obs=%h exp=%h", obs, exp); end
    for (int unsigned k = 0; k < 4; k++) begin
      cycle(1, 1, 0, 8'h00);
      exp = ev(8'hA0 + 8'(k), 1, 3 - int'(k), 1); total++;
      if (obs !== exp) begin bad++; $display("FAIL ovf_pop%0d obs=%h exp=%h", k, obs, exp); end
    end
    cycle(1, 1, 0, 8'h00);
    exp = ev(8'h00, 0, 0, 1); total++;
    if (obs !== exp) begin bad++; $display("FAIL ovf_nop obs=%h exp=%h", obs, exp); end
    cycle(1, 0, 1, 8'h00);
    exp = ev(8'h00, 0, 0, 0); total++;
    if (obs !== exp) begin bad++; $display("FAIL ovf_flush obs=%h exp=%h", obs, exp); end
  endtask

  task automatic test_full_push_pop;
    for (int unsigned k = 0; k < 4; k++) cycle(0, 0, 0, 8'hC0 + 8'(k));
    cycle(0, 1, 0, 8'hB5);
    exp = ev(8'hC0, 1, 4, 0); total++;
    if (obs !== exp) begin bad++; $display("FAIL fullpp obs=%h exp=%h", obs, exp); end
    for (int unsigned k = 0; k < 4; k++) begin
      cycle(1, 1, 0, 8'h00);
      exp = ev((k == 3) ? 8'hB5 : 8'hC1 + 8'(k), 1, 3 - int'(k), 0); total++;
      if (obs !== exp) begin bad++; $display("FAIL fullpp_pop%0d obs=%h exp=%h", k, obs, exp); end
    end
  endtask

  task automatic test_empty_push_pop;
    cycle(0, 1, 0, 8'h5C);
    exp = ev(8'h00, 0, 1, 0); total++;
    if (obs !== exp) begin bad++; $display("FAIL emptypp obs=%h exp=%h", obs, exp); end
    cycle(1, 1, 0, 8'h00);
    exp = ev(8'h5C, 1, 0, 0); total++;
    if (obs !== exp) begin bad++; $display("FAIL emptypp_pop obs=%h exp=%h", obs, exp); end
  endtask

  task automatic test_flush_load;
    for (int unsigned k = 0; k < 5; k++) cycle(0, 0, 0, 8'hD0 + 8'(k));
    cycle(1, 1, 0, 8'h00);
    exp = ev(8'hD0, 1, 3, 1); total++;
    if (obs !== exp) begin bad++; $display("FAIL flush_pre obs=%h exp=%h", obs, exp); end
    cycle(0, 1, 1, 8'h7E);
    exp = ev(8'h00, 0, 1, 0); total++;
    if (obs !== exp) begin bad++; $display("FAIL flush_load obs=%h exp=%h", obs, exp); end
    cycle(1, 1, 0, 8'h00);
    exp = ev(8'h7E, 1, 0, 0); total++;
    if (obs !== exp) begin bad++; $display("FAIL flush_pop obs=%h exp=%h", obs, exp); end
  endtask

  task automatic test_async_reset_wrap;
    for (int unsigned k = 0; k < 4; k++) cycle(0, 0, 0, 8'h11 * 8'(k + 1));
    cycle(1, 1, 0, 8'h00);
    cycle(1, 1, 0, 8'h00);
    exp = ev(8'h22, 1, 2, 0); total++;
    if (obs !== exp) begin bad++; $display("FAIL areset_pre obs=%h exp=%h", obs, exp); end
    #3 reset = 1'b1;
    #1;
    exp = ev(8'h00, 0, 0, 0); total++;
    if (obs !== exp) begin bad++; $display("FAIL areset obs=%h exp=%h", obs, exp); end
    #2 reset = 1'b0;
    cycle(0, 0, 0, 8'h40);
    exp = ev(8'h00, 0, 1, 0); total++;
    if (obs !== exp) begin bad++; $display("FAIL wrap_first obs=%h exp=%h", obs, exp); end
    for (int unsigned k = 1; k < 20; k++) begin
      cycle(0, 1, 0, 8'h40 + 8'(k));
      exp = ev(8'h40 + 8'(k) - 8'd1, 1, 1, 0); total++;
      if (obs !== exp) begin bad++; $display("FAIL wrap%0d obs=%h exp=%h", k, obs, exp); end
    end
    cycle(1, 1, 0, 8'h00);
    exp = ev(8'h53, 1, 0, 0); total++;
    if (obs !== exp) begin bad++; $display("FAIL wrap_last obs=%h exp=%h", obs, exp); end
  endtask

  initial begin
    test_reset;
    test_fifo_order;
    test_overflow;
    test_full_push_pop;
    test_empty_push_pop;
    test_flush_load;
    test_async_reset_wrap;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
